// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit types: state encoding, PC/instruction widths, reset vector.
// Also holds the fetched-word record used by the output slot and the skid register.
package fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SKID  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_dat_t;

  // PC arithmetic wraps silently at 8 bits.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched word and its PC.
// Latency: load visible the cycle after; clear wins over load; no backpressure of its own.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  fetch_dat_t load_dat,
  output logic       skid_vld,
  output fetch_dat_t skid_dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (clear) begin
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (load) begin
      skid_vld <= 1'b1;
      skid_dat <= load_dat;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one output slot plus one skid entry.
// Latency: word visible the cycle after imem_ack; stall parks a word in skid and drops imem_req.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [5:0]         opcode,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus1
);

  fetch_state_t state, state_n;

  logic [PC_W-1:0]    pc, pc_n;
  logic [PC_W-1:0]    drop_pc, drop_pc_n;
  logic               out_vld_n;
  logic [INSTR_W-1:0] instr_n;
  logic [PC_W-1:0]    pc_out_n;

  logic       slot_free;
  logic       skid_load;
  logic       skid_clear;
  logic       skid_vld;
  fetch_dat_t skid_in;
  fetch_dat_t skid_dat;

  assign slot_free = !instr_valid || !stall;
  assign skid_in   = '{instr: imem_rdata, pc: pc};

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .load_dat (skid_in),
    .skid_vld (skid_vld),
    .skid_dat (skid_dat)
  );

  // DROP keeps presenting the abandoned address until memory answers it.
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_pc : pc;

  assign opcode   = instr_out[31:26];
  assign pc_plus1 = pc_inc(pc_out);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    drop_pc_n  = drop_pc;
    out_vld_n  = instr_valid;
    instr_n    = instr_out;
    pc_out_n   = pc_out;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (redirect) begin
      out_vld_n  = 1'b0;
      skid_clear = 1'b1;
      pc_n       = redirect_pc;
      unique case (state)
        FETCH: begin
          if (!imem_ack) begin
            state_n   = DROP;
            drop_pc_n = pc;
          end else begin
            state_n = FETCH;
          end
        end
        DROP:    state_n = imem_ack ? FETCH : DROP;
        IDLE:    state_n = FETCH;
        SKID:    state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        IDLE: state_n = FETCH;

        FETCH: begin
          if (imem_ack) begin
            pc_n = pc_inc(pc);
            if (slot_free) begin
              out_vld_n = 1'b1;
              instr_n   = imem_rdata;
              pc_out_n  = pc;
            end else begin
              skid_load = 1'b1;
              state_n   = SKID;
            end
          end else if (slot_free) begin
            out_vld_n = 1'b0;
          end
        end

        SKID: begin
          if (slot_free) begin
            out_vld_n  = skid_vld;
            instr_n    = skid_dat.instr;
            pc_out_n   = skid_dat.pc;
            skid_clear = 1'b1;
            state_n    = FETCH;
          end
        end

        DROP: begin
          if (slot_free) begin
            out_vld_n = 1'b0;
          end
          if (imem_ack) begin
            state_n = FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop_pc     <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop_pc     <= drop_pc_n;
      instr_valid <= out_vld_n;
      instr_out   <= instr_n;
      pc_out      <= pc_out_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [5:0]  opcode;
  logic [7:0]  pc_out;
  logic [7:0]  pc_plus1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt = 0;
  int   lat = 0;
  logic ack_force = 1'b0;

  always #5 clk = ~clk;

  // Memory answers once a request has been waiting lat cycles; word = C0DE00xx.
  assign imem_ack   = ack_force | (imem_req && (cnt >= lat));
  assign imem_rdata = 32'hC0DE_0000 | {24'h0, imem_addr};

  always @(posedge clk) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else                       cnt <= cnt + 1;
  end

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .pc_plus1    (pc_plus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (imem_addr == a) break;
      tick();
    end
    chk("wait_addr", {24'h0, imem_addr}, {24'h0, a});
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) break;
      tick();
    end
    chk("wait_vld", {31'h0, instr_valid}, 32'h1);
  endtask

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_addr",  {24'h0, imem_addr},   32'h0);
    chk("rst_vld",   {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr_out,            32'h0);
    chk("rst_pcout", {24'h0, pc_out},      32'h0);
    rst_n = 1'b1;

    // streaming, zero-wait memory
    tick();
    chk("s_req0",  {31'h0, imem_req},    32'h1);
    chk("s_addr0", {24'h0, imem_addr},   32'h0);
    chk("s_vld0",  {31'h0, instr_valid}, 32'h0);
    tick();
    chk("s_vld1",  {31'h0, instr_valid}, 32'h1);
    chk("s_pc0",   {24'h0, pc_out},      32'h0);
    chk("s_ins0",  instr_out,            32'hC0DE_0000);
    chk("s_opc0",  {26'h0, opcode},      32'h30);
    chk("s_pp1",   {24'h0, pc_plus1},    32'h1);
    tick(); chk("s_pc1", {24'h0, pc_out}, 32'h1);
    tick(); chk("s_pc2", {24'h0, pc_out}, 32'h2);
    tick(); chk("s_pc3", {24'h0, pc_out}, 32'h3);
    tick();
    chk("s_pc4",  {24'h0, pc_out},    32'h4);
    chk("s_adr5", {24'h0, imem_addr}, 32'h5);

    // stall three cycles while word 5 returns
    stall = 1'b1;
    tick();
    chk("k_req_a", {31'h0, imem_req}, 32'h0);
    chk("k_pc_a",  {24'h0, pc_out},   32'h4);
    chk("k_vld_a", {31'h0, instr_valid}, 32'h1);
    tick();
    chk("k_req_b", {31'h0, imem_req}, 32'h0);
    chk("k_pc_b",  {24'h0, pc_out},   32'h4);
    tick();
    chk("k_req_c", {31'h0, imem_req}, 32'h0);
    chk("k_pc_c",  {24'h0, pc_out},   32'h4);
    stall = 1'b0;
    tick();
    chk("k_pc5",  {24'h0, pc_out},    32'h5);
    chk("k_ins5", instr_out,          32'hC0DE_0005);
    chk("k_adr6", {24'h0, imem_addr}, 32'h6);
    tick();
    chk("k_pc6",  {24'h0, pc_out},    32'h6);

    // asynchronous reset mid-fetch, then a stray ack while idle
    rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'h0, imem_req},    32'h0);
    chk("ar_addr",  {24'h0, imem_addr},   32'h0);
    chk("ar_vld",   {31'h0, instr_valid}, 32'h0);
    chk("ar_instr", instr_out,            32'h0);
    chk("ar_pcout", {24'h0, pc_out},      32'h0);
    lat = 3;
    ack_force = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_req1", {31'h0, imem_req},    32'h1);
    chk("ar_adr1", {24'h0, imem_addr},   32'h0);
    chk("ar_vld1", {31'h0, instr_valid}, 32'h0);
    ack_force = 1'b0;

    // redirect one cycle into a slow fetch of address 2
    wait_addr(8'h02, 20);
    tick();
    chk("d_vld0", {31'h0, instr_valid}, 32'h0);
    chk("d_adr0", {24'h0, imem_addr},   32'h2);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk("d_req1", {31'h0, imem_req},    32'h1);
    chk("d_adr1", {24'h0, imem_addr},   32'h2);
    chk("d_vld1", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("d_adr2", {24'h0, imem_addr},   32'h2);
    chk("d_vld2", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("d_adr3", {24'h0, imem_addr},   32'h40);
    chk("d_vld3", {31'h0, instr_valid}, 32'h0);
    wait_valid(20);
    chk("d_pc40",  {24'h0, pc_out}, 32'h40);
    chk("d_ins40", instr_out,       32'hC0DE_0040);

    // redirect coinciding with ack, to the top of the address space
    lat = 0;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    chk("w_vld0", {31'h0, instr_valid}, 32'h0);
    chk("w_adr",  {24'h0, imem_addr},   32'hFF);
    tick();
    chk("w_pcff", {24'h0, pc_out},   32'hFF);
    chk("w_pp1",  {24'h0, pc_plus1}, 32'h0);
    chk("w_insf", instr_out,         32'hC0DE_00FF);
    tick();
    chk("w_pc00", {24'h0, pc_out},   32'h0);
    chk("w_ins0", instr_out,         32'hC0DE_0000);

    // redirect, ack and stall together
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk("x_vld0", {31'h0, instr_valid}, 32'h0);
    chk("x_adr",  {24'h0, imem_addr},   32'h80);
    chk("x_req",  {31'h0, imem_req},    32'h1);
    tick();
    chk("x_vld1", {31'h0, instr_valid}, 32'h1);
    chk("x_pc80", {24'h0, pc_out},      32'h80);
    chk("x_ins",  instr_out,            32'hC0DE_0080);

    // second redirect while still draining the abandoned request
    lat = 3;
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    chk("r_adr0", {24'h0, imem_addr},   32'h81);
    chk("r_vld0", {31'h0, instr_valid}, 32'h0);
    redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    chk("r_adr1", {24'h0, imem_addr},   32'h81);
    tick();
    chk("r_adr2", {24'h0, imem_addr},   32'h81);
    tick();
    chk("r_adr3", {24'h0, imem_addr},   32'h20);
    wait_valid(20);
    chk("r_pc20", {24'h0, pc_out},      32'h20);
    chk("r_ins",  instr_out,            32'hC0DE_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
